mult_sequencer: RTL and testbench

Front-end and back-end wrapper for the 10-cycle shift-add `multiplier`. It accepts operand pairs on a valid/ready stream, buffers them, and drives `in1`/`in2` in the one cycle per period when the multiplier samples them. It captures `out` in the cycle the product is complete and returns tagged results on a second valid/ready stream. The multiplier itself has no handshake, so this block tracks its phase by mirroring the stage counter from the shared clock and reset.

---
 rtl/mult_seq_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mult_sequencer.sv | 113 +++++++++++
 tb/tb_mult_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared constants and payload types for the multiplier sequencer.
package mult_seq_pkg;

    localparam int         MUL_STAGES = 10;
    localparam logic [3:0] LAST_PHASE = 4'd9;
    localparam int         OP_W       = 8;
    localparam int         PROD_W     = 16;
    // Tags up to this width travel through the FIFOs; narrower tags are zero-extended.
    localparam int         TAG_MAX_W  = 8;

    typedef struct packed {
        logic [OP_W-1:0]      a;
        logic [OP_W-1:0]      b;
        logic [TAG_MAX_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [PROD_W-1:0]    product;
        logic [TAG_MAX_W-1:0] tag;
    } res_t;

    function automatic logic [3:0] next_phase(input logic [3:0] p);
        return (p == LAST_PHASE) ? 4'd0 : p + 4'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, pointers and occupancy count.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? AW'(0) : p + AW'(1);
    endfunction

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage, pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= W'(0);
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Valid/ready wrapper around the 10-stage shift-add multiplier: buffers operands,
// issues them on the multiplier's sampling phase and returns tagged products.
module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int OP_DEPTH  = 2,
    parameter int RES_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [7:0]        op_a,
    input  logic [7:0]        op_b,
    input  logic [TAG_W-1:0]  op_tag,
    output logic [7:0]        mul_in1,
    output logic [7:0]        mul_in2,
    input  logic [15:0]       mul_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_product,
    output logic [TAG_W-1:0]  res_tag,
    output logic [3:0]        phase
);

    logic [3:0]           phase_r;
    logic                 inflight_v_r;
    logic [TAG_MAX_W-1:0] inflight_tag_r;

    op_t  op_in_s;
    op_t  op_head_s;
    res_t res_in_s;
    res_t res_head_s;
    logic op_full_s;
    logic op_empty_s;
    logic res_full_s;
    logic res_empty_s;
    logic issue_s;
    logic capture_s;

    assign op_in_s  = '{a: op_a, b: op_b, tag: TAG_MAX_W'(op_tag)};
    assign res_in_s = '{product: mul_out, tag: inflight_tag_r};

    // Free result space is judged on the registered count so a product is never dropped.
    assign issue_s   = (phase_r == 4'd0) && !op_empty_s && !res_full_s;
    assign capture_s = (phase_r == LAST_PHASE) && inflight_v_r;

    assign op_ready    = !op_full_s;
    assign res_valid   = !res_empty_s;
    assign res_product = res_head_s.product;
    assign res_tag     = TAG_W'(res_head_s.tag);
    assign phase       = phase_r;

    // Operands reach the multiplier only in the cycle it samples them.
    always_comb begin
        mul_in1 = 8'd0;
        mul_in2 = 8'd0;
        if (issue_s) begin
            mul_in1 = op_head_s.a;
            mul_in2 = op_head_s.b;
        end else begin
            mul_in1 = 8'd0;
            mul_in2 = 8'd0;
        end
    end

    // Mirrored stage counter and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r        <= 4'd0;
            inflight_v_r   <= 1'b0;
            inflight_tag_r <= TAG_MAX_W'(0);
        end else begin
            phase_r <= next_phase(phase_r);
            if (phase_r == 4'd0) begin
                inflight_v_r <= issue_s;
                if (issue_s) begin
                    inflight_tag_r <= op_head_s.tag;
                end else begin
                    inflight_tag_r <= inflight_tag_r;
                end
            end else if (capture_s) begin
                inflight_v_r <= 1'b0;
            end else begin
                inflight_v_r <= inflight_v_r;
            end
        end
    end

    sync_fifo #(.W($bits(op_t)), .DEPTH(OP_DEPTH)) u_op_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_valid && op_ready),
        .wdata (op_in_s),
        .pop   (issue_s),
        .rdata (op_head_s),
        .full  (op_full_s),
        .empty (op_empty_s)
    );

    sync_fifo #(.W($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture_s),
        .wdata (res_in_s),
        .pop   (res_valid && res_ready),
        .rdata (res_head_s),
        .full  (res_full_s),
        .empty (res_empty_s)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural 10-stage multiplier model.
module tb_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  op_tag;
    logic [7:0]  mul_in1;
    logic [7:0]  mul_in2;
    logic [15:0] mul_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_product;
    logic [3:0]  res_tag;
    logic [3:0]  phase;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [3:0]  mdl_stage;
    logic [15:0] mdl_prod;

    mult_sequencer #(.TAG_W(4), .OP_DEPTH(2), .RES_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_tag(op_tag), .mul_in1(mul_in1),
        .mul_in2(mul_in2), .mul_out(mul_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_product(res_product), .res_tag(res_tag),
        .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: samples inputs at stage 0, product visible through stage 9.
    always @(posedge clk) begin
        if (rst) begin
            mdl_stage <= 4'd0;
            mdl_prod  <= 16'd0;
        end else begin
            mdl_stage <= (mdl_stage == 4'd9) ? 4'd0 : mdl_stage + 4'd1;
            if (mdl_stage == 4'd0) mdl_prod <= {8'd0, mul_in1} * {8'd0, mul_in2};
        end
    end
    assign mul_out = mdl_prod;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_a = 8'd0; op_b = 8'd0; op_tag = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        op_valid = 1'b1; op_a = a; op_b = b; op_tag = t;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL reset_op_ready: got %0d want 1", op_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %0d want 0", res_valid); end
        n_cmp++; if (res_product !== 16'd0) begin n_bad++; $display("FAIL reset_res_product: got %0d want 0", res_product); end
        n_cmp++; if (res_tag !== 4'd0) begin n_bad++; $display("FAIL reset_res_tag: got %0d want 0", res_tag); end
        n_cmp++; if ({mul_in1, mul_in2} !== 16'd0) begin n_bad++; $display("FAIL reset_mul_in: got %0d/%0d want 0/0", mul_in1, mul_in2); end
        n_cmp++; if (phase !== 4'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    endtask

    task automatic test_single();
        do_reset();
        offer(8'd13, 8'd11, 4'd3);
        step();
        op_valid = 1'b0;
        goto(5);
        n_cmp++; if (phase !== 4'd5) begin n_bad++; $display("FAIL single_phase5: got %0d want 5", phase); end
        goto(10);
        n_cmp++; if (phase !== 4'd0) begin n_bad++; $display("FAIL single_phase_wrap: got %0d want 0", phase); end
        n_cmp++; if (mul_in1 !== 8'd13) begin n_bad++; $display("FAIL single_mul_in1: got %0d want 13", mul_in1); end
        n_cmp++; if (mul_in2 !== 8'd11) begin n_bad++; $display("FAIL single_mul_in2: got %0d want 11", mul_in2); end
        goto(19);
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %0d want 0", res_valid); end
        goto(20);
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0d want 1", res_valid); end
        n_cmp++; if (res_product !== 16'd143) begin n_bad++; $display("FAIL single_product: got %0d want 143", res_product); end
        n_cmp++; if (res_tag !== 4'd3) begin n_bad++; $display("FAIL single_tag: got %0d want 3", res_tag); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained: got %0d want 0", res_valid); end
    endtask

    task automatic test_extremes();
        do_reset();
        offer(8'd255, 8'd255, 4'd5);
        step();
        offer(8'd0, 8'd200, 4'd6);
        step();
        op_valid = 1'b0;
        goto(30);
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL ext_valid: got %0d want 1", res_valid); end
        n_cmp++; if (res_product !== 16'd65025) begin n_bad++; $display("FAIL ext_max_product: got %0d want 65025", res_product); end
        n_cmp++; if (res_tag !== 4'd5) begin n_bad++; $display("FAIL ext_tag5: got %0d want 5", res_tag); end
        res_ready = 1'b1;
        step();
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL ext_second_valid: got %0d want 1", res_valid); end
        n_cmp++; if (res_product !== 16'd0) begin n_bad++; $display("FAIL ext_zero_product: got %0d want 0", res_product); end
        n_cmp++; if (res_tag !== 4'd6) begin n_bad++; $display("FAIL ext_tag6: got %0d want 6", res_tag); end
        step();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL ext_drained: got %0d want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        int   idx = 0;
        logic acc;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            if (idx < 4) offer(8'(idx + 1), 8'(idx + 2), 4'(idx));
            else op_valid = 1'b0;
            if (c == 2) begin
                n_cmp++; if (op_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_op_full: got %0d want 0", op_ready); end
            end
            if (c == 10) begin
                n_cmp++; if (op_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_on_pop: got %0d want 0", op_ready); end
                n_cmp++; if (mul_in1 !== 8'd1) begin n_bad++; $display("FAIL b2b_issue0: got %0d want 1", mul_in1); end
            end
            if (c == 20) begin
                n_cmp++; if (mul_in1 !== 8'd2) begin n_bad++; $display("FAIL b2b_issue1: got %0d want 2", mul_in1); end
            end
            if (c == 30) begin
                n_cmp++; if ({mul_in1, mul_in2} !== 16'd0) begin n_bad++; $display("FAIL b2b_no_issue_full: got %0d/%0d want 0/0", mul_in1, mul_in2); end
            end
            if (c == 40) begin
                n_cmp++; if (idx !== 4) begin n_bad++; $display("FAIL b2b_accepted: got %0d want 4", idx); end
                n_cmp++; if (op_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_op_full_late: got %0d want 0", op_ready); end
            end
            acc = op_valid && op_ready;
            if (c < 40) begin
                step();
                if (acc) idx++;
            end
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int waited = 0;
            while (!res_valid && waited < 40) begin
                step();
                waited++;
            end
            n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_drain_timeout: result %0d got valid %0d want 1", k, res_valid); end
            n_cmp++; if (res_tag !== 4'(k)) begin n_bad++; $display("FAIL b2b_order: got tag %0d want %0d", res_tag, k); end
            n_cmp++; if (res_product !== 16'((k + 1) * (k + 2))) begin n_bad++; $display("FAIL b2b_product: got %0d want %0d", res_product, (k + 1) * (k + 2)); end
            step();
        end
        res_ready = 1'b0;
    endtask

    task automatic test_bubble();
        logic seen = 1'b0;
        do_reset();
        n_cmp++; if ({mul_in1, mul_in2} !== 16'd0) begin n_bad++; $display("FAIL bubble_mul_in: got %0d/%0d want 0/0", mul_in1, mul_in2); end
        for (int i = 0; i < 25; i++) begin
            step();
            if (res_valid !== 1'b0 || mul_in1 !== 8'd0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL bubble_activity: got %0d want 0", seen); end
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        do_reset();
        offer(8'd7, 8'd9, 4'd4);
        step();
        op_valid = 1'b0;
        goto(15);
        n_cmp++; if (phase !== 4'd5) begin n_bad++; $display("FAIL midrst_phase_before: got %0d want 5", phase); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_res_valid: got %0d want 0", res_valid); end
        n_cmp++; if (phase !== 4'd0) begin n_bad++; $display("FAIL midrst_phase: got %0d want 0", phase); end
        n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_op_ready: got %0d want 1", op_ready); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_stale_result: got %0d want 0", seen); end
    endtask

    task automatic test_hold();
        logic moved = 1'b0;
        do_reset();
        offer(8'd12, 8'd12, 4'd9);
        step();
        offer(8'd3, 8'd5, 4'd10);
        step();
        op_valid = 1'b0;
        goto(20);
        n_cmp++; if (res_product !== 16'd144) begin n_bad++; $display("FAIL hold_product: got %0d want 144", res_product); end
        n_cmp++; if (res_tag !== 4'd9) begin n_bad++; $display("FAIL hold_tag: got %0d want 9", res_tag); end
        for (int i = 0; i < 15; i++) begin
            step();
            if (res_valid !== 1'b1 || res_product !== 16'd144 || res_tag !== 4'd9) moved = 1'b1;
        end
        n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL hold_stable: got %0d want 0", moved); end
        res_ready = 1'b1;
        step();
        n_cmp++; if (res_product !== 16'd15) begin n_bad++; $display("FAIL hold_next_product: got %0d want 15", res_product); end
        n_cmp++; if (res_tag !== 4'd10) begin n_bad++; $display("FAIL hold_next_tag: got %0d want 10", res_tag); end
        step();
        res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL hold_drained: got %0d want 0", res_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_bubble();
        test_reset_midflight();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
